lfsr_rng_hexdisp: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random generator with seed load, run/step/hold modes, lock-up protection, period-wrap detection and built-in multi-digit hex seven-segment decode. It is the board-level random source for the NVBoard/FPGA demo path. Switches supply the seed and mode, the state drives N seven-segment digits, and a status pulse goes to an LED.

---
 rtl/lfsr_rng_hexdisp.sv | 120 ++++++++++++
 tb/tb_lfsr_rng_hexdisp.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_hexdisp.sv
// Fibonacci LFSR random source with seed load, RUN/STEP/HOLD advance control,
// period-wrap detection and a hex seven-segment decode of the current state.
module lfsr_rng_hexdisp #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 'h1D,
  parameter int               DIV          = 500,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 'd1,
  parameter int               NDIG         = (WIDTH + 3) / 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  seed_i,
  input  logic              load_i,
  input  logic [1:0]        mode_i,
  input  logic              step_i,
  output logic [WIDTH-1:0]  state_o,
  output logic              adv_o,
  output logic              wrap_o,
  output logic [NDIG*7-1:0] seg_o
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] loaded_q, loaded_d;
  logic [DW-1:0]    div_q, div_d;
  logic             step_q;
  logic             adv_q, adv_d;
  logic             wrap_q, wrap_d;

  logic             fb;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] seed_eff;
  logic             run_tc;
  logic             step_edge;

  always_comb begin
    fb         = ^(state_q & TAPS);
    next_state = {fb, state_q[WIDTH-1:1]};
    // An all-zero seed would lock the register, so it is replaced
    seed_eff   = (seed_i == '0) ? SEED_DEFAULT : seed_i;
    run_tc     = (mode_i == MODE_RUN) && (div_q == DIV_LAST);
    step_edge  = (mode_i == MODE_STEP) && step_i && !step_q;

    state_d  = state_q;
    loaded_d = loaded_q;
    div_d    = '0;
    adv_d    = 1'b0;
    wrap_d   = 1'b0;

    if (load_i) begin
      state_d  = seed_eff;
      loaded_d = seed_eff;
    end else begin
      if (mode_i == MODE_RUN && !run_tc) div_d = div_q + 1'b1;
      if (run_tc || step_edge) begin
        state_d = next_state;
        adv_d   = 1'b1;
        wrap_d  = (next_state == loaded_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEED_DEFAULT;
      loaded_q <= SEED_DEFAULT;
      div_q    <= '0;
      step_q   <= 1'b0;
      adv_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      div_q    <= div_d;
      step_q   <= step_i;
      adv_q    <= adv_d;
      wrap_q   <= wrap_d;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  logic [NDIG*4-1:0] state_pad;

  always_comb begin
    state_pad = (NDIG*4)'(state_q);
    seg_o     = '0;
    for (int i = 0; i < NDIG; i++) begin
      seg_o[7*i +: 7] = hex7(state_pad[4*i +: 4]);
    end
  end

  assign state_o = state_q;
  assign adv_o   = adv_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_lfsr_rng_hexdisp.sv
// Directed bench for lfsr_rng_hexdisp at WIDTH=8, TAPS=1D; DIV shortened to keep
// the full 255-step period run short.
module tb_lfsr_rng_hexdisp;

  localparam int DIV = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  seed_i;
  logic        load_i;
  logic [1:0]  mode_i;
  logic        step_i;
  logic [7:0]  state_o;
  logic        adv_o;
  logic        wrap_o;
  logic [13:0] seg_o;

  int checks   = 0;
  int failures = 0;

  lfsr_rng_hexdisp #(
    .WIDTH(8), .TAPS(8'h1D), .DIV(DIV), .SEED_DEFAULT(8'h01)
  ) dut (
    .clk(clk), .reset(reset), .seed_i(seed_i), .load_i(load_i),
    .mode_i(mode_i), .step_i(step_i), .state_o(state_o), .adv_o(adv_o),
    .wrap_o(wrap_o), .seg_o(seg_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] s, input logic [1:0] m);
    seed_i = s; mode_i = m; load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  logic [7:0] step_exp [5];
  int adv_cnt, wrap_cnt, wrap_at, bad_spacing, first_adv;
  logic [7:0] wrap_state;

  initial begin
    step_exp[0] = 8'h80; step_exp[1] = 8'h40; step_exp[2] = 8'h20;
    step_exp[3] = 8'h10; step_exp[4] = 8'h88;

    reset = 1'b1; seed_i = 8'h00; load_i = 1'b0; mode_i = 2'b00; step_i = 1'b0;
    #12;
    check("reset_state", state_o, 8'h01);
    check("reset_adv", adv_o, 1'b0);
    check("reset_wrap", wrap_o, 1'b0);
    check("reset_seg", seg_o, {7'b0000001, 7'b1001111});

    // HOLD for 1000 cycles, also exercising the 11 encoding
    reset = 1'b0;
    adv_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      mode_i = (i < 500) ? 2'b00 : 2'b11;
      tick();
      if (adv_o) adv_cnt++;
    end
    check("hold_adv_count", adv_cnt, 0);
    check("hold_state", state_o, 8'h01);
    check("hold_seg", seg_o, {7'b0000001, 7'b1001111});

    // STEP sequence
    do_load(8'h01, 2'b10);
    check("step_load_state", state_o, 8'h01);
    check("step_load_adv", adv_o, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step_i = 1'b1;
      tick();
      check($sformatf("step%0d_state", k), state_o, step_exp[k]);
      check($sformatf("step%0d_adv", k), adv_o, 1'b1);
      step_i = 1'b0;
      tick();
      check($sformatf("step%0d_adv_low", k), adv_o, 1'b0);
    end
    step_i = 1'b1;
    adv_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (adv_o) adv_cnt++;
    end
    step_i = 1'b0;
    check("step_held_adv_count", adv_cnt, 1);
    check("step_held_state", state_o, 8'hC4);

    // zero seed substitution
    do_load(8'h00, 2'b10);
    check("zero_seed_state", state_o, 8'h01);
    check("zero_seed_adv", adv_o, 1'b0);

    // load coincident with a step rising edge
    seed_i = 8'h5A; mode_i = 2'b10; load_i = 1'b1; step_i = 1'b1;
    tick();
    load_i = 1'b0;
    check("load_vs_step_state", state_o, 8'h5A);
    check("load_vs_step_adv", adv_o, 1'b0);
    check("seg_5A", seg_o, {7'b0100100, 7'b0001000});
    tick();
    check("load_vs_step_noadv", state_o, 8'h5A);
    step_i = 1'b0;

    // RUN over one full period
    do_load(8'h01, 2'b01);
    adv_cnt = 0; wrap_cnt = 0; wrap_at = 0; bad_spacing = 0; wrap_state = 8'h00;
    for (int c = 1; c <= 255 * DIV; c++) begin
      tick();
      if (adv_o) begin
        adv_cnt++;
        if (c % DIV != 0) bad_spacing++;
      end else if (c % DIV == 0) begin
        bad_spacing++;
      end
      if (wrap_o) begin
        wrap_cnt++;
        wrap_at = adv_cnt;
        wrap_state = state_o;
      end
    end
    check("run_adv_count", adv_cnt, 255);
    check("run_spacing_errors", bad_spacing, 0);
    check("run_wrap_count", wrap_cnt, 1);
    check("run_wrap_at", wrap_at, 255);
    check("run_wrap_state", wrap_state, 8'h01);

    // load at divider terminal count
    for (int i = 0; i < DIV - 1; i++) tick();
    do_load(8'h3C, 2'b01);
    check("load_vs_tc_state", state_o, 8'h3C);
    check("load_vs_tc_adv", adv_o, 1'b0);
    check("seg_3C", seg_o, {7'b0000110, 7'b0110001});
    adv_cnt = 0;
    for (int i = 0; i < DIV - 1; i++) begin
      tick();
      if (adv_o) adv_cnt++;
    end
    check("load_vs_tc_div_cleared", adv_cnt, 0);
    tick();
    check("load_vs_tc_first_adv", adv_o, 1'b1);
    check("load_vs_tc_next_state", state_o, 8'h9E);

    // reset mid-RUN with divider part way
    for (int i = 0; i < DIV / 2; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrun_reset_state", state_o, 8'h01);
    check("midrun_reset_adv", adv_o, 1'b0);
    check("midrun_reset_wrap", wrap_o, 1'b0);
    #2;
    reset = 1'b0;
    first_adv = 0;
    for (int c = 1; c <= 2 * DIV && first_adv == 0; c++) begin
      tick();
      if (adv_o) first_adv = c;
    end
    check("midrun_first_adv_cycle", first_adv, DIV);
    check("midrun_first_adv_state", state_o, 8'h80);

    // display of AF
    do_load(8'hAF, 2'b00);
    check("seg_AF", seg_o, {7'b0001000, 7'b0111000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
